// File: rtl/tt_um_seq_divider_hhrb98.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per enabled cycle.
// Companion to the 4x4 array multiplier; divides a product back by one of its operands.
module tt_um_seq_divider_hhrb98 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    // Handshake: start is taken only in IDLE with ena=1; operands are captured on that edge.
    // busy is high for the 8 RUN steps, done is high for the single DONE state, and the
    // results/div_by_zero stay stable from done until the next accepted start.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] dq;
    logic [4:0] r;
    logic [3:0] dv;
    logic [2:0] cnt;

    logic [5:0] t;
    logic       fits;
    logic [4:0] r_step;
    logic [7:0] dq_step;

    // r[4] is zero between steps; carrying it keeps the trial compare over the full remainder.
    always_comb begin
        t       = {r, dq[7]};
        fits    = (t >= {2'b00, dv});
        r_step  = fits ? (t[4:0] - {1'b0, dv}) : t[4:0];
        dq_step = {dq[6:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == 4'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == 3'd7) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq          <= 8'd0;
            r           <= 5'd0;
            dv          <= 4'd0;
            cnt         <= 3'd0;
            quotient    <= 8'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dq          <= dividend;
                        dv          <= divisor;
                        r           <= 5'd0;
                        cnt         <= 3'd0;
                        div_by_zero <= 1'b0;
                        // A zero divisor skips the iterations and reports saturated results.
                        if (divisor == 4'd0) begin
                            quotient    <= 8'hFF;
                            remainder   <= 4'hF;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    dq  <= dq_step;
                    r   <= r_step;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        quotient  <= dq_step;
                        remainder <= r_step[3:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Bench for the sequential divider: arithmetic reference model compared every cycle,
// plus directed divisions with hand-computed quotients, remainders and latencies.
module tb_tt_um_seq_divider_hhrb98;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    tt_um_seq_divider_hhrb98 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks enabled edges since capture; results come from plain / and %.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_q    = 8'd0;
    logic [3:0] m_r    = 4'd0;
    logic       m_dz   = 1'b0;
    int         m_left = 0;
    int         pend_q = 0;
    int         pend_r = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_q    = 8'd0;
            m_r    = 4'd0;
            m_dz   = 1'b0;
            m_left = 0;
        end else if (ena) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_q    = pend_q[7:0];
                    m_r    = pend_r[3:0];
                end
            end else if (start) begin
                if (divisor == 4'd0) begin
                    m_done = 1'b1;
                    m_q    = 8'hFF;
                    m_r    = 4'hF;
                    m_dz   = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_left = 8;
                    m_dz   = 1'b0;
                    pend_q = int'(dividend) / int'(divisor);
                    pend_r = int'(dividend) % int'(divisor);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("div_by_zero", int'(div_by_zero), int'(m_dz));
        if (!m_busy) begin
            chk("quotient", int'(quotient), int'(m_q));
            chk("remainder", int'(remainder), int'(m_r));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait for done, counting edges since the capture edge; n holds edges already seen.
    task automatic wait_done(input int n_in, output int n_out);
        int n;
        n = n_in;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout got 0 expected 1 at %0t", $time);
        end
        n_out = n;
    endtask

    task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                          input int exp_q, input int exp_r, input int exp_dz, input int exp_lat);
        int n;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
        wait_done(1, n);
        chk("latency", n, exp_lat);
        chk("q_lit", int'(quotient), exp_q);
        chk("r_lit", int'(remainder), exp_r);
        chk("dz_lit", int'(div_by_zero), exp_dz);
        tick();
        chk("done_fall", int'(done), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int nd;
        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'($urandom_range(0, 1));
        dividend = 8'($urandom_range(0, 255));
        divisor  = 4'($urandom_range(0, 15));
        repeat (3) tick();
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(div_by_zero), 0);

        start = 1'b0;
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_q", int'(quotient), 0);
        chk("idle_done", int'(done), 0);

        // basic and edge values
        do_div(8'd200, 4'd7, 28, 4, 0, 9);
        do_div(8'd255, 4'd1, 255, 0, 0, 9);
        do_div(8'd0, 4'd5, 0, 0, 0, 9);
        do_div(8'd14, 4'd15, 0, 14, 0, 9);
        do_div(8'd255, 4'd15, 17, 0, 0, 9);

        // divide by zero, then a normal division clears the flag
        do_div(8'h55, 4'd0, 255, 15, 1, 1);
        do_div(8'd100, 4'd10, 10, 0, 0, 9);

        // ena dropped for 3 cycles mid-RUN, then held low while in DONE
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        ena = 1'b0;
        repeat (3) tick();
        ena = 1'b1;
        wait_done(7, n);
        chk("stall_latency", n, 12);
        chk("stall_q", int'(quotient), 28);
        chk("stall_r", int'(remainder), 4);
        ena = 1'b0;
        repeat (2) tick();
        chk("stall_done_hold", int'(done), 1);
        ena = 1'b1;
        tick();
        chk("stall_done_fall", int'(done), 0);

        // start pulsed during RUN with new operands is ignored
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        wait_done(4, n);
        chk("ign_latency", n, 9);
        chk("ign_q", int'(quotient), 28);
        chk("ign_r", int'(remainder), 4);
        tick();

        // start held high: back-to-back captures every 10 enabled edges
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd10;
        nd = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (done) nd++;
        end
        start = 1'b0;
        chk("b2b_dones", nd, 2);
        repeat (12) tick();

        // reset mid-RUN
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_q", int'(quotient), 0);
        chk("midrst_r", int'(remainder), 0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("postrst_q", int'(quotient), 0);
        chk("postrst_done", int'(done), 0);

        // multiplier round trip
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(8'(a * b), 4'(b), a, 0, 0, 9);
            end
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
